rom_port_arbiter: RTL and testbench

Shares the single genrom read port between the core's instruction-fetch unit and its data/constant-load unit. Latches the winning request onto the ROM address/extra/bound pins and waits out the ROM read latency. Returns data and error to the owning requester. Also owns the ROM bound registers, which software/config logic writes through a small config port.

---
 rtl/rom_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/rom_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_rom_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// rom_port_arbiter shared types and sizing helpers.
// Imported by rr_arb2 and rom_port_arbiter.
package rom_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  typedef enum logic {
    REQ_FETCH,
    REQ_DATA
  } req_e;

  localparam int CNT_W = 3;

  function automatic int data_w(input int extra);
    return (2 ** extra) * 8;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between fetch and data; win is one-hot {data, fetch}.
// ARB_FIXED_PRIO_EN: fetch always wins a tie and the last input is dropped.
module rr_arb2
  import rom_arb_pkg::*;
(
  input  logic       f_req,
  input  logic       d_req,
`ifndef ARB_FIXED_PRIO_EN
  input  req_e       last,
`endif
  output logic [1:0] win
);

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      f_req:            win = 2'b01;
      (d_req & ~f_req): win = 2'b10;
      default:          win = 2'b00;
    endcase
  end
`else
  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      (f_req & d_req):
        win = (last == REQ_DATA) ? 2'b01 : 2'b10;
      (f_req & ~d_req): win = 2'b01;
      (d_req & ~f_req): win = 2'b10;
      default:          win = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the genrom read port between fetch and data-load requesters.
// ARB_FIXED_PRIO_EN selects fixed fetch priority instead of round-robin.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int MEM_ADDR    = 3,
  parameter int MEM_EXTRA   = 4,
  parameter int ROM_LATENCY = 1,
  localparam int DW = data_w(MEM_EXTRA)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f_req,
  input  logic [MEM_ADDR:0]    f_addr,
  input  logic [MEM_EXTRA-1:0] f_extra,
  output logic                 f_gnt,
  output logic                 f_valid,
  output logic [DW-1:0]        f_data,
  output logic                 f_error,
  input  logic                 d_req,
  input  logic [MEM_ADDR:0]    d_addr,
  input  logic [MEM_EXTRA-1:0] d_extra,
  output logic                 d_gnt,
  output logic                 d_valid,
  output logic [DW-1:0]        d_data,
  output logic                 d_error,
  input  logic                 cfg_we,
  input  logic [MEM_ADDR:0]    cfg_lower,
  input  logic [MEM_ADDR:0]    cfg_upper,
  output logic                 busy,
  output logic [MEM_ADDR:0]    mem_addr,
  output logic [MEM_EXTRA-1:0] mem_extra,
  output logic [MEM_ADDR:0]    mem_lower_bound,
  output logic [MEM_ADDR:0]    mem_upper_bound,
  input  logic [DW-1:0]        mem_data,
  input  logic                 mem_error
);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  req_e             owner;
  logic             pend;
  logic [MEM_ADDR:0] sh_lo, sh_hi;
  logic [1:0]       win;
  logic             grant, apply, done;

`ifdef ARB_FIXED_PRIO_EN
  rr_arb2 u_arb (
    .f_req (f_req),
    .d_req (d_req),
    .win   (win)
  );
`else
  req_e last;

  rr_arb2 u_arb (
    .f_req (f_req),
    .d_req (d_req),
    .last  (last),
    .win   (win)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last <= REQ_DATA;
    else if (grant) last <= win[1] ? REQ_DATA : REQ_FETCH;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A pending bound update always takes the IDLE slot before any grant.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant   = 1'b0;
    apply   = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pend) begin
          apply = 1'b1;
        end else if ((f_req | d_req) & ~reset) begin
          grant   = 1'b1;
          cnt_n   = CNT_W'(ROM_LATENCY);
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  assign f_gnt = grant & win[0];
  assign d_gnt = grant & win[1];
  assign busy  = (state != ST_IDLE) | pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner           <= REQ_FETCH;
      pend            <= 1'b0;
      sh_lo           <= '0;
      sh_hi           <= '1;
      mem_addr        <= '0;
      mem_extra       <= '0;
      mem_lower_bound <= '0;
      mem_upper_bound <= '1;
      f_valid         <= 1'b0;
      d_valid         <= 1'b0;
      f_data          <= '0;
      d_data          <= '0;
      f_error         <= 1'b0;
      d_error         <= 1'b0;
    end else begin
      f_valid <= done & (owner == REQ_FETCH);
      d_valid <= done & (owner == REQ_DATA);
      if (grant) begin
        owner     <= win[1] ? REQ_DATA : REQ_FETCH;
        mem_addr  <= win[1] ? d_addr : f_addr;
        mem_extra <= win[1] ? d_extra : f_extra;
      end
      if (apply) begin
        mem_lower_bound <= sh_lo;
        mem_upper_bound <= sh_hi;
      end
      // A write landing on the apply cycle stays pending for the next slot.
      if (cfg_we) begin
        sh_lo <= cfg_lower;
        sh_hi <= cfg_upper;
        pend  <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
      if (done && owner == REQ_FETCH) begin
        f_data  <= mem_data;
        f_error <= mem_error;
      end
      if (done && owner == REQ_DATA) begin
        d_data  <= mem_data;
        d_error <= mem_error;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Testbench for rom_port_arbiter: directed scenarios plus randomized
// traffic checked every cycle against a transaction-level model.
module tb_rom_port_arbiter;

  localparam int MA  = 3;
  localparam int MX  = 4;
  localparam int LAT = 3;
  localparam int DW  = (2 ** MX) * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, d_req;
  logic [MA:0]   f_addr, d_addr;
  logic [MX-1:0] f_extra, d_extra;
  logic          f_gnt, f_valid, f_error;
  logic          d_gnt, d_valid, d_error;
  logic [DW-1:0] f_data, d_data, mem_data;
  logic          cfg_we;
  logic [MA:0]   cfg_lower, cfg_upper;
  logic          busy;
  logic [MA:0]   mem_addr, mem_lower_bound, mem_upper_bound;
  logic [MX-1:0] mem_extra;
  logic          mem_error;

  always #5 clk = ~clk;

  rom_port_arbiter #(
    .MEM_ADDR    (MA),
    .MEM_EXTRA   (MX),
    .ROM_LATENCY (LAT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .f_req           (f_req),
    .f_addr          (f_addr),
    .f_extra         (f_extra),
    .f_gnt           (f_gnt),
    .f_valid         (f_valid),
    .f_data          (f_data),
    .f_error         (f_error),
    .d_req           (d_req),
    .d_addr          (d_addr),
    .d_extra         (d_extra),
    .d_gnt           (d_gnt),
    .d_valid         (d_valid),
    .d_data          (d_data),
    .d_error         (d_error),
    .cfg_we          (cfg_we),
    .cfg_lower       (cfg_lower),
    .cfg_upper       (cfg_upper),
    .busy            (busy),
    .mem_addr        (mem_addr),
    .mem_extra       (mem_extra),
    .mem_lower_bound (mem_lower_bound),
    .mem_upper_bound (mem_upper_bound),
    .mem_data        (mem_data),
    .mem_error       (mem_error)
  );

  // ROM image: byte k of the word at address a holds a+k.
  function automatic logic [DW-1:0] rom_word(input logic [MA:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 8; k++) w[8*k +: 8] = 8'(a + k);
    return w;
  endfunction

  assign mem_data  = rom_word(mem_addr);
  assign mem_error = (mem_addr < mem_lower_bound) ||
                     (mem_addr > mem_upper_bound);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access, described by the
  // cycle at which its response is due.
  int            cyc;
  int            free_at;
  bit            pend;
  logic [MA:0]   sh_lo, sh_hi, m_lo, m_hi, m_addr;
  logic [MX-1:0] m_extra;
  bit            last_d;
  bit            r_act, r_own;
  int            r_cyc;
  logic [DW-1:0] r_data, ef_data, ed_data;
  bit            r_err, ef_err, ed_err;
  bit            ev_f, ev_d, eg_f, eg_d, m_idle;

  logic          s_f_gnt, s_d_gnt, s_f_valid, s_d_valid;
  logic          s_f_error, s_d_error, s_busy;
  logic [DW-1:0] s_f_data, s_d_data;
  logic [MA:0]   s_mem_addr, s_lo, s_hi;

  task automatic model_init();
    free_at = cyc;
    pend    = 0;
    sh_lo   = '0;
    sh_hi   = '1;
    m_lo    = '0;
    m_hi    = '1;
    m_addr  = '0;
    m_extra = '0;
    last_d  = 1;
    r_act   = 0;
    ef_data = '0;
    ed_data = '0;
    ef_err  = 0;
    ed_err  = 0;
    s_f_gnt = 0;
    s_d_gnt = 0;
  endtask

  task automatic check_cycle();
    logic [MA:0] a;
    ev_f = 0;
    ev_d = 0;
    if (r_act && r_cyc == cyc) begin
      r_act = 0;
      if (r_own) begin
        ev_d = 1; ed_data = r_data; ed_err = r_err;
      end else begin
        ev_f = 1; ef_data = r_data; ef_err = r_err;
      end
    end
    m_idle = (cyc >= free_at);
    eg_f = 0;
    eg_d = 0;
    if (m_idle && !pend) begin
      if (f_req && d_req) begin
`ifdef ARB_FIXED_PRIO_EN
        eg_f = 1;
`else
        if (last_d) eg_f = 1;
        else        eg_d = 1;
`endif
      end else begin
        eg_f = f_req;
        eg_d = d_req;
      end
    end
    chk("f_gnt", f_gnt, eg_f);
    chk("d_gnt", d_gnt, eg_d);
    chk("f_valid", f_valid, ev_f);
    chk("d_valid", d_valid, ev_d);
    chk("f_data", f_data, ef_data);
    chk("d_data", d_data, ed_data);
    chk("f_error", f_error, ef_err);
    chk("d_error", d_error, ed_err);
    chk("busy", busy, !m_idle || pend);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_extra", mem_extra, m_extra);
    chk("lower", mem_lower_bound, m_lo);
    chk("upper", mem_upper_bound, m_hi);
    s_f_gnt = f_gnt;     s_d_gnt = d_gnt;
    s_f_valid = f_valid; s_d_valid = d_valid;
    s_f_data = f_data;   s_d_data = d_data;
    s_f_error = f_error; s_d_error = d_error;
    s_busy = busy;       s_mem_addr = mem_addr;
    s_lo = mem_lower_bound;
    s_hi = mem_upper_bound;
    if (m_idle && pend) begin
      m_lo = sh_lo;
      m_hi = sh_hi;
      pend = 0;
    end else if (eg_f || eg_d) begin
      a       = eg_d ? d_addr : f_addr;
      m_addr  = a;
      m_extra = eg_d ? d_extra : f_extra;
      free_at = cyc + LAT + 1;
      r_act   = 1;
      r_cyc   = cyc + LAT + 1;
      r_own   = eg_d;
      r_data  = rom_word(a);
      r_err   = (a < m_lo) || (a > m_hi);
      last_d  = eg_d;
    end
    if (cfg_we) begin
      sh_lo = cfg_lower;
      sh_hi = cfg_upper;
      pend  = 1;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1;
    f_req  = 0;
    d_req  = 0;
    cfg_we = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_f_valid", f_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_upper", mem_upper_bound, 4'hF);
    chk("rst_lower", mem_lower_bound, 4'h0);
    chk("rst_f_data", f_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_init();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  int       ng;
  logic [3:0] order;

  initial begin
    reset = 1;
    f_req = 0; d_req = 0; cfg_we = 0;
    f_addr = 0; d_addr = 0; f_extra = 0; d_extra = 0;
    cfg_lower = 0; cfg_upper = 0;
    cyc = 0;
    model_init();
    @(posedge clk);
    #1;
    do_reset();

    // single fetch: grant, address held through WAIT, response later
    f_req = 1; f_addr = 4; f_extra = 0;
    tick();
    chk("t1_gnt", s_f_gnt, 1);
    f_req = 0;
    for (int i = 0; i < LAT; i++) begin
      tick();
      chk("t1_hold_addr", s_mem_addr, 4);
      chk("t1_early_valid", s_f_valid, 0);
    end
    tick();
    chk("t1_valid", s_f_valid, 1);
    chk("t1_data", s_f_data[7:0], 8'h04);
    chk("t1_err", s_f_error, 0);
    chk("t1_dvalid", s_d_valid, 0);

    // tie between both requesters from reset
    do_reset();
    f_req = 1; d_req = 1;
    f_addr = 5; d_addr = 6; f_extra = 1; d_extra = 2;
    ng = 0;
    order = '0;
    for (int i = 0; i < 6 * (LAT + 1) && ng < 4; i++) begin
      tick();
      if (s_f_gnt || s_d_gnt) begin
        order[ng[1:0]] = s_d_gnt;
        ng++;
      end
    end
    f_req = 0; d_req = 0;
    chk("t2_count", ng, 4);
`ifdef ARB_FIXED_PRIO_EN
    chk("t2_order", order, 4'b0000);
`else
    chk("t2_order", order, 4'b1010);
`endif
    repeat (LAT + 1) tick();

    // bound write during WAIT applies only at the next IDLE slot
    f_req = 1; f_addr = 0;
    tick();
    chk("t3_gnt", s_f_gnt, 1);
    f_req = 0;
    cfg_we = 1; cfg_lower = 2; cfg_upper = 5;
    d_req = 1; d_addr = 7; d_extra = 0;
    tick();
    cfg_we = 0;
    chk("t3_busy", s_busy, 1);
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      chk("t3_no_dgnt", s_d_gnt, 0);
      chk("t3_lo_hold", s_lo, 0);
      chk("t3_hi_hold", s_hi, 4'hF);
    end
    tick();
    chk("t3_fvalid", s_f_valid, 1);
    chk("t3_apply_no_gnt", s_d_gnt, 0);
    chk("t3_busy_pend", s_busy, 1);
    tick();
    chk("t3_dgnt", s_d_gnt, 1);
    chk("t3_lo_new", s_lo, 2);
    chk("t3_hi_new", s_hi, 5);
    d_req = 0;
    repeat (LAT) tick();
    tick();
    chk("t3_dvalid", s_d_valid, 1);
    chk("t3_derr", s_d_error, 1);

    // back-to-back data loads with req held
    d_req = 1; d_addr = 1;
    tick();
    chk("t5_gnt1", s_d_gnt, 1);
    d_addr = 2;
    repeat (LAT) tick();
    tick();
    chk("t5_valid1", s_d_valid, 1);
    chk("t5_gnt2", s_d_gnt, 1);
    chk("t5_data1", s_d_data[7:0], 8'h01);
    d_req = 0;
    repeat (LAT) tick();
    tick();
    chk("t5_valid2", s_d_valid, 1);
    chk("t5_data2", s_d_data[7:0], 8'h02);

    // reset in the first WAIT cycle drops the response
    f_req = 1; f_addr = 9;
    tick();
    chk("t4_gnt", s_f_gnt, 1);
    f_req = 0;
    do_reset();
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk("t4_no_fvalid", s_f_valid, 0);
    end

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (!f_req || s_f_gnt) begin
        f_req = ($urandom_range(0, 99) < 40);
        f_addr = 4'($urandom);
        f_extra = 4'($urandom);
      end else if ($urandom_range(0, 99) < 5) begin
        f_req = 0;
      end
      if (!d_req || s_d_gnt) begin
        d_req = ($urandom_range(0, 99) < 40);
        d_addr = 4'($urandom);
        d_extra = 4'($urandom);
      end else if ($urandom_range(0, 99) < 5) begin
        d_req = 0;
      end
      cfg_we = ($urandom_range(0, 99) < 4);
      cfg_lower = 4'($urandom);
      cfg_upper = 4'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      else                             tick();
    end
    f_req = 0; d_req = 0; cfg_we = 0;
    repeat (LAT + 3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
